idle_toggle_bank: RTL and testbench
===================================

Name: idle_toggle_bank

Overview:
- Multi-channel, parametrised idle-timeout event generator.
- Each channel counts consecutive idle cycles (no kick). When the count reaches a programmable period, the channel fires and restarts its count.
- A fire either toggles the channel output (toggle mode) or produces a one-cycle pulse (pulse mode).
- Used as a heartbeat/timeout source feeding LED blinkers and watchdog-style logic.

Parameters:
- CH, 4, number of independent channels
- CNT_W, 8, width of period input and per-channel idle counter
- FCNT_W, 8, width of per-channel fire counter (FIRE_COUNT_EN only)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- en  in  1  global enable; low freezes all counters
- mode  in  1  0 = toggle on fire, 1 = one-cycle pulse on fire
- period  in  CNT_W  idle cycles per fire, shared by all channels
- kick  in  CH  per-channel activity strobe; restarts that channel's idle count
- out  out  CH  per-channel registered output
- fire  out  CH  registered per-channel fire strobe, high one cycle per fire
- any_fire  out  1  registered OR of fire
- fire_cnt  out  CH*FCNT_W  saturating fire counts, channel i at [i*FCNT_W +: FCNT_W] (FIRE_COUNT_EN only)

Behaviour:
- Reset: clk is the single clock; rst is asynchronous and active-high. Asserting rst immediately clears every cnt[i], out, fire, any_fire and fire_cnt to 0, regardless of clk. Deassertion is synchronous to the next edge.
- Per channel i, the internal cnt[i] is CNT_W bits. Each rising edge, in priority order:
  1. rst: covered above.
  2. en=0: cnt[i] holds; fire[i]=0. In toggle mode out[i] holds; in pulse mode out[i]=0.
  3. kick[i]=1: cnt[i]<=0; no fire. Kick beats a terminal count in the same cycle.
  4. period==0: channel disabled; cnt[i]<=0; no fire.
  5. cnt[i] >= period-1: terminal. cnt[i]<=0; fire[i]<=1.
  6. Otherwise: cnt[i]<=cnt[i]+1; fire[i]<=0.
- Using >= for the terminal test means shrinking period mid-count fires on the next enabled cycle instead of wrapping through 2^CNT_W.
- period==1 with no kick fires every cycle.
- Output update:
  - mode=0: out[i] <= out[i] ^ fire_next[i].
  - mode=1: out[i] <= fire_next[i].
  - Switching toggle→pulse drops out to 0 next cycle unless that channel fires. Switching pulse→toggle keeps the current out as the toggle start value.
- Latency: a fire is visible on out/fire at the same edge where cnt wraps. With a constant period P and no kicks, fire is spaced exactly P cycles apart. The first fire after reset/kick lands P edges later.
- Channels are fully independent. Simultaneous fires on several channels are all reported.
- any_fire is a registered OR of fire_next; it asserts in the same cycle as fire.
- Counters never overflow: cnt stays <= period-1 <= 2^CNT_W-2.
- Reset mid-count discards all progress; there is no partial-count retention.

Optional Feature:
- Macro: IDLE_TOGGLE_FIRE_COUNT_EN.
- Defined: fire_cnt port present. Each channel increments its counter on fire[i] and saturates at 2^FCNT_W-1. Reset clears it; kick and en do not affect it.
- Undefined: the fire_cnt port and its counters are absent. All other behaviour is identical.

Decomposition:
- Shared package idle_toggle_pkg holds:
  - mode encodings MODE_TOGGLE=1'b0, MODE_PULSE=1'b1;
  - default widths (CNT_W_DEF=8, FCNT_W_DEF=8).
- One sub-module, idle_toggle_ch: a single-channel counter, terminal compare and out/fire register (plus optional fire counter).
- The top level instantiates CH copies via a generate loop and builds the any_fire OR.

Test Plan:
1. Reset/idle: CH=4, CNT_W=8, period=4, mode=0, en=1, kick=0, release rst. Expect out toggles 0→1 at edge 4, 1→0 at edge 8; fire pulses on edges 4, 8, 12.
2. Kick priority: period=4, kick[1] at every 3rd cycle. Expect channel 1 never fires and out[1]=0, while channels 0/2/3 toggle every 4 cycles. Kick coincident with the terminal cycle also suppresses the fire.
3. Pulse mode/period edge cases: mode=1, period=1 gives out=fire=1 on every edge. period=0 gives out=0 with no fires. period 200→3 mid-count with cnt=50 fires on the next edge, then every 3 cycles.
4. Enable/async reset: en=0 for 10 cycles at cnt=2 freezes the channel; after re-enable it fires 2 edges later. Asserting rst between clock edges clears out and fire immediately, without waiting for clk.
5. Mode switch: toggle mode with out[0]=1, switch to mode=1 with no fire. Expect out[0]=0 next edge and a single-cycle pulse at the next terminal.
6. FIRE_COUNT_EN: FCNT_W=4, period=1, run 20 cycles. Expect fire_cnt[i] saturates at 15; kick and en toggling leave it unchanged; rst returns it to 0.

Source files
------------

// File: rtl/idle_toggle_pkg.sv
// ============================================================================
// Module   : idle_toggle_pkg
// Brief    : Shared mode encodings and default widths for the idle toggle bank.
// Revision : 1.0
// ============================================================================
`default_nettype none

package idle_toggle_pkg;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    localparam int CNT_W_DEF  = 8;
    localparam int FCNT_W_DEF = 8;

endpackage

`default_nettype wire

// File: rtl/idle_toggle_ch.sv
// ============================================================================
// Module   : idle_toggle_ch
// Brief    : One idle-timeout channel: idle counter, terminal compare, out/fire
//            registers; saturating fire counter when IDLE_TOGGLE_FIRE_COUNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module idle_toggle_ch
    import idle_toggle_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
`ifdef IDLE_TOGGLE_FIRE_COUNT_EN
    ,
    parameter int FCNT_W = FCNT_W_DEF
`endif
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [CNT_W-1:0] period,
    input  logic             kick,
    output logic             out,
    output logic             fire,
    output logic             fire_next
`ifdef IDLE_TOGGLE_FIRE_COUNT_EN
    ,
    output logic [FCNT_W-1:0] fire_cnt
`endif
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_fire_next;
    logic             w_out_next;
    logic             r_out;
    logic             r_fire;

    // ">=" rather than "==" so a period shrunk below the current count fires
    // immediately instead of wrapping through the full counter range.
    always_comb begin
        w_cnt_next  = r_cnt;
        w_fire_next = 1'b0;
        if (en) begin
            if (kick) begin
                w_cnt_next = '0;
            end else if (period == '0) begin
                w_cnt_next = '0;
            end else if (r_cnt >= (period - CNT_W'(1))) begin
                w_cnt_next  = '0;
                w_fire_next = 1'b1;
            end else begin
                w_cnt_next = r_cnt + CNT_W'(1);
            end
        end
    end

    // With en low w_fire_next is 0, so toggle mode holds and pulse mode clears.
    assign w_out_next = (mode == MODE_PULSE) ? w_fire_next : (r_out ^ w_fire_next);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_out  <= 1'b0;
            r_fire <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_out  <= w_out_next;
            r_fire <= w_fire_next;
        end
    end

    assign out       = r_out;
    assign fire      = r_fire;
    assign fire_next = w_fire_next;

`ifdef IDLE_TOGGLE_FIRE_COUNT_EN
    logic [FCNT_W-1:0] r_fcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fcnt <= '0;
        end else if (w_fire_next && (r_fcnt != {FCNT_W{1'b1}})) begin
            r_fcnt <= r_fcnt + FCNT_W'(1);
        end
    end

    assign fire_cnt = r_fcnt;
`endif

endmodule

`default_nettype wire

// File: rtl/idle_toggle_bank.sv
// ============================================================================
// Module   : idle_toggle_bank
// Brief    : CH independent idle-timeout channels with toggle/pulse outputs and
//            a registered any_fire; fire_cnt port under IDLE_TOGGLE_FIRE_COUNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module idle_toggle_bank
    import idle_toggle_pkg::*;
#(
    parameter int CH     = 4,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int FCNT_W = FCNT_W_DEF
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [CNT_W-1:0] period,
    input  logic [CH-1:0]    kick,
    output logic [CH-1:0]    out,
    output logic [CH-1:0]    fire,
    output logic             any_fire
`ifdef IDLE_TOGGLE_FIRE_COUNT_EN
    ,
    output logic [CH*FCNT_W-1:0] fire_cnt
`endif
);

    logic [CH-1:0] w_fire_next;
    logic          r_any_fire;

`ifndef IDLE_TOGGLE_FIRE_COUNT_EN
    localparam int c_unused_fcnt_w = FCNT_W;
`endif

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            idle_toggle_ch #(
                .CNT_W     (CNT_W)
`ifdef IDLE_TOGGLE_FIRE_COUNT_EN
                ,
                .FCNT_W    (FCNT_W)
`endif
            ) u_ch (
                .clk       (clk),
                .rst       (rst),
                .en        (en),
                .mode      (mode),
                .period    (period),
                .kick      (kick[gi]),
                .out       (out[gi]),
                .fire      (fire[gi]),
                .fire_next (w_fire_next[gi])
`ifdef IDLE_TOGGLE_FIRE_COUNT_EN
                ,
                .fire_cnt  (fire_cnt[gi*FCNT_W +: FCNT_W])
`endif
            );
        end
    endgenerate

    // Registered from the next-state fires so it lines up with the fire bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_any_fire <= 1'b0;
        end else begin
            r_any_fire <= |w_fire_next;
        end
    end

    assign any_fire = r_any_fire;

endmodule

`default_nettype wire

// File: tb/tb_idle_toggle_bank.sv
// ============================================================================
// Module   : tb_idle_toggle_bank
// Brief    : Directed self-checking bench for idle_toggle_bank (CH=4, CNT_W=8).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_idle_toggle_bank;

    logic       clk;
    logic       rst;
    logic       en;
    logic       mode;
    logic [7:0] period;
    logic [3:0] kick;
    logic [3:0] out;
    logic [3:0] fire;
    logic       any_fire;
`ifdef IDLE_TOGGLE_FIRE_COUNT_EN
    logic [15:0] fire_cnt;
`endif

    int checks;
    int errors;

    idle_toggle_bank #(
        .CH       (4),
        .CNT_W    (8),
        .FCNT_W   (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .period   (period),
        .kick     (kick),
        .out      (out),
        .fire     (fire),
        .any_fire (any_fire)
`ifdef IDLE_TOGGLE_FIRE_COUNT_EN
        ,
        .fire_cnt (fire_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        en = 1'b1; mode = 1'b0; period = 8'd4; kick = 4'h0;
        rst = 1'b1;
        tick();
        checks++;
        if (out !== 4'h0 || fire !== 4'h0 || any_fire !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out=%h fire=%h any=%b, want 0 0 0", out, fire, any_fire);
        end
        rst = 1'b0;
        begin
            logic [3:0] exp_out;
            exp_out = 4'h0;
            for (int e = 1; e <= 12; e++) begin
                tick();
                if (e % 4 == 0) exp_out = ~exp_out;
                checks++;
                if (fire !== ((e % 4 == 0) ? 4'hF : 4'h0) || out !== exp_out ||
                    any_fire !== (e % 4 == 0)) begin
                    errors++;
                    $display("FAIL toggle_edge%0d: out=%h fire=%h any=%b, want out=%h fire=%h",
                             e, out, fire, any_fire, exp_out, (e % 4 == 0) ? 4'hF : 4'h0);
                end
            end
        end
    endtask

    task automatic test_kick();
        logic [3:0] exp_out;
        do_reset();
        exp_out = 4'h0;
        for (int e = 1; e <= 12; e++) begin
            kick = (e % 3 == 0) ? 4'b0010 : 4'b0000;
            tick();
            if (e % 4 == 0) exp_out = exp_out ^ 4'b1101;
            checks++;
            if (fire !== ((e % 4 == 0) ? 4'b1101 : 4'b0000) || out !== exp_out) begin
                errors++;
                $display("FAIL kick_edge%0d: out=%h fire=%h, want out=%h fire=%h",
                         e, out, fire, exp_out, (e % 4 == 0) ? 4'b1101 : 4'b0000);
            end
        end
        kick = 4'h0;
        do_reset();
        for (int e = 1; e <= 8; e++) begin
            kick = (e == 4) ? 4'b0001 : 4'b0000;
            tick();
            if (e == 4) begin
                checks++;
                if (fire !== 4'b1110) begin
                    errors++;
                    $display("FAIL kick_at_terminal: fire=%h want e", fire);
                end
            end
            if (e == 8) begin
                checks++;
                if (fire !== 4'hF || out !== 4'b0001) begin
                    errors++;
                    $display("FAIL kick_restart: fire=%h out=%h want f 1", fire, out);
                end
            end
        end
        kick = 4'h0;
    endtask

    task automatic test_pulse_period();
        do_reset();
        mode = 1'b1; period = 8'd1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            checks++;
            if (fire !== 4'hF || out !== 4'hF || any_fire !== 1'b1) begin
                errors++;
                $display("FAIL period1_edge%0d: out=%h fire=%h any=%b want f f 1", e, out, fire, any_fire);
            end
        end
        period = 8'd0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            checks++;
            if (fire !== 4'h0 || out !== 4'h0 || any_fire !== 1'b0) begin
                errors++;
                $display("FAIL period0_edge%0d: out=%h fire=%h any=%b want 0 0 0", e, out, fire, any_fire);
            end
        end
        do_reset();
        period = 8'd200;
        for (int e = 1; e <= 50; e++) tick();
        period = 8'd3;
        tick();
        checks++;
        if (fire !== 4'hF || out !== 4'hF) begin
            errors++;
            $display("FAIL shrink_period: out=%h fire=%h want f f", out, fire);
        end
        for (int e = 1; e <= 3; e++) begin
            tick();
            checks++;
            if (fire !== ((e == 3) ? 4'hF : 4'h0)) begin
                errors++;
                $display("FAIL shrink_cadence%0d: fire=%h want %h", e, fire, (e == 3) ? 4'hF : 4'h0);
            end
        end
    endtask

    task automatic test_enable_async_reset();
        mode = 1'b0; period = 8'd4;
        do_reset();
        tick();
        tick();
        en = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            checks++;
            if (fire !== 4'h0 || out !== 4'h0) begin
                errors++;
                $display("FAIL en_freeze%0d: out=%h fire=%h want 0 0", e, out, fire);
            end
        end
        en = 1'b1;
        tick();
        checks++;
        if (fire !== 4'h0) begin
            errors++;
            $display("FAIL en_resume1: fire=%h want 0", fire);
        end
        tick();
        checks++;
        if (fire !== 4'hF || out !== 4'hF || any_fire !== 1'b1) begin
            errors++;
            $display("FAIL en_resume2: out=%h fire=%h any=%b want f f 1", out, fire, any_fire);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out !== 4'h0 || fire !== 4'h0 || any_fire !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: out=%h fire=%h any=%b want 0 0 0", out, fire, any_fire);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_mode_switch();
        mode = 1'b0; period = 8'd4; en = 1'b1;
        do_reset();
        for (int e = 1; e <= 4; e++) tick();
        checks++;
        if (out !== 4'hF) begin
            errors++;
            $display("FAIL switch_pre: out=%h want f", out);
        end
        mode = 1'b1;
        for (int e = 5; e <= 9; e++) begin
            tick();
            checks++;
            if (out !== ((e == 8) ? 4'hF : 4'h0) || fire !== ((e == 8) ? 4'hF : 4'h0)) begin
                errors++;
                $display("FAIL switch_edge%0d: out=%h fire=%h want %h", e, out, fire,
                         (e == 8) ? 4'hF : 4'h0);
            end
        end
    endtask

`ifdef IDLE_TOGGLE_FIRE_COUNT_EN
    task automatic test_fire_count();
        mode = 1'b1; period = 8'd1; en = 1'b1; kick = 4'h0;
        do_reset();
        checks++;
        if (fire_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL fcnt_reset: fire_cnt=%h want 0000", fire_cnt);
        end
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e == 5) begin
                checks++;
                if (fire_cnt !== 16'h5555) begin
                    errors++;
                    $display("FAIL fcnt_5: fire_cnt=%h want 5555", fire_cnt);
                end
            end
        end
        checks++;
        if (fire_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL fcnt_sat: fire_cnt=%h want ffff", fire_cnt);
        end
        kick = 4'hF;
        tick();
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        kick = 4'h0;
        checks++;
        if (fire_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL fcnt_hold: fire_cnt=%h want ffff", fire_cnt);
        end
        do_reset();
        kick = 4'hF;
        tick();
        kick = 4'h0;
        checks++;
        if (fire_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL fcnt_clear: fire_cnt=%h want 0000", fire_cnt);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; en = 1'b1; mode = 1'b0; period = 8'd4; kick = 4'h0;
        test_reset();
        test_kick();
        test_pulse_period();
        test_enable_async_reset();
        test_mode_switch();
`ifdef IDLE_TOGGLE_FIRE_COUNT_EN
        test_fire_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
